// File: rtl/motor_cmd_rx.sv
// Purpose: UART command receiver; validates A5/MODE/CMD/SUM frames and holds the last good mode/cmd.
// Latency: outputs update one clock after the SUM byte's stop-bit sample; cmd_valid pulses in that cycle.
// Backpressure: none; the serial link is free-running, so bad or late frames are dropped with a frame_err pulse.
// Optional link watchdog built when MOTOR_CMD_WDOG_EN is defined.
module motor_cmd_rx #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned WDOG_MS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [1:0] model_s,
  output logic [5:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_ok
);

  localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;
  localparam int unsigned GAP_CLKS = 2 * 10 * BIT_CLKS;
  localparam int CW = $clog2(BIT_CLKS + 1);
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'(GAP_CLKS - 1);
  localparam logic [5:0]    CMD_STOP = 6'b001001;

  // Byte receiver states; R_BRK waits for the line to return high after a bad stop bit.
  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_BRK   = 3'd4;

  // Frame parser states.
  localparam logic [1:0] P_HUNT = 2'd0;
  localparam logic [1:0] P_MODE = 2'd1;
  localparam logic [1:0] P_CMD  = 2'd2;
  localparam logic [1:0] P_SUM  = 2'd3;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]    rxs_q, rxs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_stb, stop_err;

  logic [1:0]    ps_q, ps_d;
  logic [1:0]    mode_q, mode_d;
  logic [5:0]    cmdb_q, cmdb_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          perr, commit;

  logic [1:0]    model_s_q;
  logic [5:0]    cmd_q;
  logic          cmd_valid_q, frame_err_q, link_ok_q;
  logic          wdog_fire;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Byte receiver next-state: half-bit start check, then centre sampling of 8 data bits and stop.
  always_comb begin
    rxs_d    = rxs_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_stb = 1'b0;
    stop_err = 1'b0;
    case (rxs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rxs_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          rxs_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rxs_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            byte_stb = 1'b1;
            rxs_d    = R_IDLE;
          end else begin
            stop_err = 1'b1;
            rxs_d    = R_BRK;
          end
        end
      end
      R_BRK: begin
        cnt_d = '0;
        if (rx_s2_q) rxs_d = R_IDLE;
      end
      default: begin
        cnt_d = '0;
        rxs_d = R_IDLE;
      end
    endcase
  end

  // Byte receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      rxs_q <= rxs_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  // Parser next-state: field checks on each strobed byte, inter-byte gap timeout while mid-frame.
  always_comb begin
    ps_d   = ps_q;
    mode_d = mode_q;
    cmdb_d = cmdb_q;
    gap_d  = (ps_q == P_HUNT || byte_stb) ? '0 : gap_q + 1'b1;
    perr   = 1'b0;
    commit = 1'b0;
    if (stop_err) begin
      ps_d = P_HUNT;
    end else if (byte_stb) begin
      case (ps_q)
        P_HUNT: if (sh_q == 8'hA5) ps_d = P_MODE;
        P_MODE: begin
          if (sh_q[7:2] == 6'd0 && sh_q[1:0] != 2'd0) begin
            mode_d = sh_q[1:0];
            ps_d   = P_CMD;
          end else begin
            perr = 1'b1;
            ps_d = P_HUNT;
          end
        end
        P_CMD: begin
          if (sh_q[7:6] == 2'd0) begin
            cmdb_d = sh_q[5:0];
            ps_d   = P_SUM;
          end else begin
            perr = 1'b1;
            ps_d = P_HUNT;
          end
        end
        default: begin
          if (sh_q == (8'hA5 ^ {6'd0, mode_q} ^ {2'd0, cmdb_q})) commit = 1'b1;
          else                                                     perr   = 1'b1;
          ps_d = P_HUNT;
        end
      endcase
    end else if (ps_q != P_HUNT && gap_q == GAP_M1) begin
      perr = 1'b1;
      ps_d = P_HUNT;
    end
  end

  // Parser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= P_HUNT;
      mode_q <= '0;
      cmdb_q <= '0;
      gap_q  <= '0;
    end else begin
      ps_q   <= ps_d;
      mode_q <= mode_d;
      cmdb_q <= cmdb_d;
      gap_q  <= gap_d;
    end
  end

`ifdef MOTOR_CMD_WDOG_EN
  localparam int unsigned PRE_CLKS = CLK_HZ / 1000;
  localparam int PW = $clog2(PRE_CLKS + 1);
  localparam int MW = $clog2(WDOG_MS + 1);
  localparam logic [PW-1:0] PRE_M1 = PW'(PRE_CLKS - 1);
  localparam logic [MW-1:0] MS_LIM = MW'(WDOG_MS);

  logic [PW-1:0] pre_q;
  logic [MW-1:0] ms_q;

  // Millisecond watchdog restarted by every commit; saturates at the limit so the stop stays forced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (commit) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (ms_q != MS_LIM) begin
      if (pre_q == PRE_M1) begin
        pre_q <= '0;
        ms_q  <= ms_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign wdog_fire = (ms_q == MS_LIM);
`else
  assign wdog_fire = 1'b0;
`endif

  // Output registers: commit wins over a watchdog stop so link_ok recovers in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_s_q   <= 2'b00;
      cmd_q       <= CMD_STOP;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      link_ok_q   <= 1'b0;
    end else begin
      cmd_valid_q <= commit;
      frame_err_q <= stop_err | perr;
      if (commit) begin
        model_s_q <= mode_q;
        cmd_q     <= cmdb_q;
        link_ok_q <= 1'b1;
      end else if (wdog_fire) begin
        cmd_q     <= CMD_STOP;
        link_ok_q <= 1'b0;
      end
    end
  end

  assign model_s   = model_s_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign link_ok   = link_ok_q;

endmodule

// File: tb/tb_motor_cmd_rx.sv
// Bench for motor_cmd_rx at 10 clocks per bit; expected commits queued as frames are sent.
module tb_motor_cmd_rx;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] model_s;
  logic [5:0] cmd;
  logic       cmd_valid, frame_err, link_ok;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  always #5 clk = ~clk;

  motor_cmd_rx #(.CLK_HZ(1_000_000), .BAUD(100_000), .WDOG_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .model_s(model_s), .cmd(cmd),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .link_ok(link_ok)
  );

  // Scoreboard monitor: every cmd_valid pops one expected {mode,cmd}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid || frame_err) begin
        checks++;
        if (cmd_valid && frame_err) begin
          failures++;
          $display("FAIL excl: cmd_valid and frame_err both high at %0t", $time);
        end
      end
      if (frame_err) n_err++;
      if (cmd_valid) begin
        n_valid++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_commit: got model_s=%b cmd=%b, none expected", model_s, cmd);
        end else begin
          mon_e = exp_q.pop_front();
          if ({model_s, cmd} !== mon_e || link_ok !== 1'b1) begin
            failures++;
            $display("FAIL commit: got {model_s,cmd}=%b link_ok=%b, exp %b link_ok=1",
                     {model_s, cmd}, link_ok, mon_e);
          end
        end
      end
    end
  end

  function automatic logic [7:0] fsum(input logic [7:0] m, input logic [7:0] c);
    return 8'hA5 ^ m ^ c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v = b;
    @(negedge clk);
    rx = 1'b0;
    repeat (BC - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = v[i];
      repeat (BC - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = stop_bit;
    repeat (BC - 1) @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] m, input logic [7:0] c, input logic [7:0] s);
    send_byte(8'hA5, 1'b1);
    send_byte(m, 1'b1);
    send_byte(c, 1'b1);
    send_byte(s, 1'b1);
  endtask

  task automatic expect_counts(input string nm, input int v0, input int e0, input int dv, input int de);
    repeat (40) @(negedge clk);
    checks++;
    if (n_valid - v0 != dv || n_err - e0 != de || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s counts: got commits=%0d errs=%0d pending=%0d, exp commits=%0d errs=%0d pending=0",
               nm, n_valid - v0, n_err - e0, exp_q.size(), dv, de);
    end
  endtask

  task automatic expect_out(input string nm, input logic [1:0] m, input logic [5:0] c, input logic l);
    checks++;
    if (model_s !== m || cmd !== c || link_ok !== l) begin
      failures++;
      $display("FAIL %s outputs: got model_s=%b cmd=%b link_ok=%b, exp %b %b %b",
               nm, model_s, cmd, link_ok, m, c, l);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: got cmd_valid=%b frame_err=%b, exp 0 0", cmd_valid, frame_err);
    end
    expect_out("reset", 2'b00, 6'b001001, 1'b0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    expect_out("post_reset_idle", 2'b00, 6'b001001, 1'b0);
  endtask

  task automatic test_basic();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({2'b10, 6'b000001});
    send_frame(8'h02, 8'h01, 8'hA6);
    expect_counts("basic", v0, e0, 1, 0);
    expect_out("basic", 2'b10, 6'b000001, 1'b1);
  endtask

  task automatic test_checksum();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({2'b10, 6'b000101});
    send_frame(8'h02, 8'h05, fsum(8'h02, 8'h05));
    send_frame(8'h02, 8'h05, fsum(8'h02, 8'h05) ^ 8'h03);
    expect_counts("checksum", v0, e0, 1, 1);
    expect_out("checksum", 2'b10, 6'b000101, 1'b1);
  endtask

  task automatic test_stop_err();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b0);
    exp_q.push_back({2'b11, 6'b001001});
    send_frame(8'h03, 8'h09, 8'hAF);
    expect_counts("stop_err", v0, e0, 1, 1);
    expect_out("stop_err", 2'b11, 6'b001001, 1'b1);
  endtask

  task automatic test_gap();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (300) @(negedge clk);
    send_byte(8'h04, 1'b1);
    send_byte(8'hA3, 1'b1);
    expect_counts("gap", v0, e0, 0, 1);
    expect_out("gap", 2'b11, 6'b001001, 1'b1);
  endtask

  task automatic test_field_limits();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    expect_counts("hunt_ignore", v0, e0, 0, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    expect_counts("mode_zero", v0, e0, 0, 1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    expect_counts("mode_four", v0, e0, 0, 2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    expect_counts("cmd_40", v0, e0, 0, 3);
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    expect_counts("glitch", v0, e0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({2'b01, 6'b111111});
    exp_q.push_back({2'b01, 6'b111111});
    send_frame(8'h01, 8'h3F, fsum(8'h01, 8'h3F));
    send_frame(8'h01, 8'h3F, fsum(8'h01, 8'h3F));
    expect_counts("back_to_back", v0, e0, 2, 0);
    expect_out("back_to_back", 2'b01, 6'b111111, 1'b1);
  endtask

  task automatic test_link_idle();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({2'b01, 6'b000011});
    send_frame(8'h01, 8'h03, 8'hA7);
    repeat (1500) @(negedge clk);
    expect_out("idle_1p5ms", 2'b01, 6'b000011, 1'b1);
    repeat (700) @(negedge clk);
`ifdef MOTOR_CMD_WDOG_EN
    expect_out("wdog_fired", 2'b01, 6'b001001, 1'b0);
    exp_q.push_back({2'b01, 6'b000011});
    send_frame(8'h01, 8'h03, 8'hA7);
    expect_counts("wdog", v0, e0, 2, 0);
    expect_out("wdog_restore", 2'b01, 6'b000011, 1'b1);
`else
    expect_out("no_wdog", 2'b01, 6'b000011, 1'b1);
    expect_counts("no_wdog", v0, e0, 1, 0);
`endif
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset_mid", 2'b00, 6'b001001, 1'b0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h03, 1'b1);
    send_byte(8'hA7, 1'b1);
    expect_counts("reset_mid_discard", v0, e0, 0, 0);
    exp_q.push_back({2'b01, 6'b000011});
    send_frame(8'h01, 8'h03, 8'hA7);
    expect_counts("reset_mid_recover", v0, e0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_stop_err();
    test_gap();
    test_field_limits();
    test_glitch();
    test_back_to_back();
    test_link_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
